// File: rtl/add_arb_2.sv
// Two-requester signed adder sharing a single WIDTH-bit adder; one operation in
// flight, round-robin grant when both requesters are pending.
module add_arb_2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_sum,
    output logic             resp0_ovf,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_sum,
    output logic             resp1_ovf,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum0_q, sum0_d, sum1_q, sum1_d;
    logic             ovf0_q, ovf0_d, ovf1_q, ovf1_d;
    logic [1:0]       rvalid_q, rvalid_d;

    logic             any_valid_s;
    logic             gnt_s;
    logic [WIDTH-1:0] add_s;
    logic             add_ovf_s;
    logic             resp_ready_s;

    function automatic logic signed_ovf(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Grant selection, shared adder and handshake decode
    always_comb begin
        any_valid_s  = req0_valid | req1_valid;
        gnt_s        = (req0_valid && req1_valid) ? rr_q : req1_valid;
        add_s        = a_q + b_q;
        add_ovf_s    = signed_ovf(a_q, b_q, add_s);
        resp_ready_s = gnt_q ? resp1_ready : resp0_ready;
        req0_ready   = (state_q == IDLE) && !rst && any_valid_s && (gnt_s == 1'b0);
        req1_ready   = (state_q == IDLE) && !rst && any_valid_s && (gnt_s == 1'b1);
    end

    // Next-state logic for the IDLE/EXEC/RESP sequence
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sum0_d   = sum0_q;
        sum1_d   = sum1_q;
        ovf0_d   = ovf0_q;
        ovf1_d   = ovf1_q;
        rvalid_d = rvalid_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    state_d = EXEC;
                    gnt_d   = gnt_s;
                    a_d     = gnt_s ? req1_a : req0_a;
                    b_d     = gnt_s ? req1_b : req0_b;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = RESP;
                if (gnt_q) begin
                    sum1_d   = add_s;
                    ovf1_d   = add_ovf_s;
                    rvalid_d = 2'b10;
                end else begin
                    sum0_d   = add_s;
                    ovf0_d   = add_ovf_s;
                    rvalid_d = 2'b01;
                end
            end
            RESP: begin
                // Results stay frozen until the granted requester consumes them
                if (resp_ready_s) begin
                    state_d  = IDLE;
                    rr_d     = ~gnt_q;
                    rvalid_d = 2'b00;
                end else begin
                    state_d  = RESP;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 2'b00;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum0_q   <= '0;
            sum1_q   <= '0;
            ovf0_q   <= 1'b0;
            ovf1_q   <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum0_q   <= sum0_d;
            sum1_q   <= sum1_d;
            ovf0_q   <= ovf0_d;
            ovf1_q   <= ovf1_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign resp0_valid = rvalid_q[0];
    assign resp1_valid = rvalid_q[1];
    assign resp0_sum   = sum0_q;
    assign resp1_sum   = sum1_q;
    assign resp0_ovf   = ovf0_q;
    assign resp1_ovf   = ovf1_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_add_arb_2.sv
// Directed and randomized checks for the shared-adder arbiter add_arb_2.
module tb_add_arb_2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [63:0] resp0_sum, resp1_sum;
    logic        resp0_ovf, resp1_ovf, busy;

    int n_vec  = 0;
    int n_miss = 0;

    add_arb_2 #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(resp0_sum), .resp0_ovf(resp0_ovf),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(resp1_sum), .resp1_ovf(resp1_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: 65-bit sign-extended add; overflow when the two top bits differ.
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] w;
        w = {a[63], a} + {b[63], b};
        return {w[64] != w[63], w[63:0]};
    endfunction

    task automatic run_op(input int n, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_s, input logic exp_o, input string tag);
        if (n == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        else begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        #1;
        chk({tag, "_ready"}, (n == 0) ? req0_ready : req1_ready, 64'd1);
        step();
        // Scramble operands after acceptance; the in-flight result must not move
        if (n == 0) begin req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; end
        else begin req1_valid = 1'b0; req1_a = ~a; req1_b = ~b; end
        chk({tag, "_busy"}, busy, 64'd1);
        chk({tag, "_early"}, (n == 0) ? resp0_valid : resp1_valid, 64'd0);
        step();
        chk({tag, "_valid"}, (n == 0) ? resp0_valid : resp1_valid, 64'd1);
        chk({tag, "_sum"}, (n == 0) ? resp0_sum : resp1_sum, exp_s);
        chk({tag, "_ovf"}, (n == 0) ? resp0_ovf : resp1_ovf, exp_o);
        if (n == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        chk({tag, "_done"}, {busy, resp0_valid, resp1_valid}, 64'd0);
    endtask

    initial begin
        logic [64:0] q0[$];
        logic [64:0] q1[$];
        logic [64:0] e;
        logic        acc0, acc1;
        int          ops, cyc;

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 64'd0; req0_b = 64'd0; req1_a = 64'd0; req1_b = 64'd0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        step();
        step();
        chk("rst_state", {busy, resp0_valid, resp1_valid, resp0_ovf, resp1_ovf}, 64'd0);
        chk("rst_sums", resp0_sum | resp1_sum, 64'd0);
        chk("rst_ready", {req0_ready, req1_ready}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("idle_ready", {req0_ready, req1_ready}, 64'd0);

        run_op(0, 64'd10, -64'sd15, -64'sd5, 1'b0, "r0_10m15");
        run_op(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b1, "r1_maxp1");
        run_op(1, -64'sd1, -64'sd1, -64'sd2, 1'b0, "r1_m1m1");
        chk("r0_hold_sum", resp0_sum, -64'sd5);
        run_op(0, 64'h8000_0000_0000_0000, -64'sd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "r0_minm1");

        // Round-robin from reset: req0 first, then alternate
        rst = 1'b1; step(); rst = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd15; req0_b = -64'sd10;
        req1_valid = 1'b1; req1_a = 64'd10; req1_b = -64'sd10;
        #1 chk("rr_first", {req0_ready, req1_ready}, 64'b10);
        step(); req0_valid = 1'b0; step();
        chk("rr_r0_sum", {resp0_valid, resp0_sum}, {1'b1, 64'd5});
        resp0_ready = 1'b1; step(); resp0_ready = 1'b0;
        #1 chk("rr_second", {req0_ready, req1_ready}, 64'b01);
        step(); req1_valid = 1'b0; step();
        chk("rr_r1_sum", {resp1_valid, resp1_sum}, {1'b1, 64'd0});
        resp1_ready = 1'b1; step(); resp1_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2;
        req1_valid = 1'b1; req1_a = 64'd4; req1_b = 64'd5;
        #1 chk("rr_third", {req0_ready, req1_ready}, 64'b10);
        step(); req0_valid = 1'b0; step();
        chk("rr_r0_sum2", {resp0_valid, resp0_sum}, {1'b1, 64'd3});
        resp0_ready = 1'b1; step(); resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd7; req0_b = 64'd8;
        #1 chk("rr_fourth", {req0_ready, req1_ready}, 64'b01);
        step(); req0_valid = 1'b0; req1_valid = 1'b0; step();
        chk("rr_r1_sum2", {resp1_valid, resp1_sum}, {1'b1, 64'd9});
        resp1_ready = 1'b1; step(); resp1_ready = 1'b0;

        // Back-pressure in RESP
        req0_valid = 1'b1; req0_a = 64'd20; req0_b = 64'd22;
        step(); req0_valid = 1'b0; step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_hold", {resp0_valid, resp0_sum, req0_ready, req1_ready}, {1'b1, 64'd42, 2'b00});
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1;
        step(); resp0_ready = 1'b0;
        chk("stall_release", {busy, resp0_valid, resp0_sum}, {2'b00, 64'd42});

        // Stray resp ready while idle
        resp1_ready = 1'b1; step(); resp1_ready = 1'b0;
        chk("stray_ready", {busy, resp1_valid, resp1_sum}, {2'b00, 64'd9});

        // Reset during EXEC discards the operation
        req1_valid = 1'b1; req1_a = 64'd100; req1_b = 64'd200;
        step(); req1_valid = 1'b0;
        chk("exec_busy", busy, 64'd1);
        rst = 1'b1; req0_valid = 1'b1;
        #1 chk("rst_ready_low", {req0_ready, req1_ready}, 64'd0);
        step(); rst = 1'b0; req0_valid = 1'b0;
        chk("post_rst", {busy, resp0_valid, resp1_valid, resp0_ovf, resp1_ovf}, 64'd0);
        chk("post_rst_sums", resp0_sum | resp1_sum, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_ghost_resp", {resp0_valid, resp1_valid}, 64'd0);
        end
        run_op(0, 64'd3, 64'd4, 64'd7, 1'b0, "post_rst_op");

        // Random sweep against the reference model
        ops = 0; cyc = 0;
        while (ops < 1000 && cyc < 40000) begin
            if (!req0_valid && $urandom_range(1, 0) == 1) begin
                req0_valid = 1'b1; req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            end
            if (!req1_valid && $urandom_range(1, 0) == 1) begin
                req1_valid = 1'b1; req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            end
            resp0_ready = ($urandom_range(1, 0) == 1);
            resp1_ready = ($urandom_range(1, 0) == 1);
            #1;
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0) q0.push_back(model(req0_a, req0_b));
            if (acc1) q1.push_back(model(req1_a, req1_b));
            if (resp0_valid && resp0_ready) begin
                chk("sweep0_pending", 64'(q0.size()), 64'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("sweep0_res", {resp0_ovf, resp0_sum}, e);
                end
                ops++;
            end
            if (resp1_valid && resp1_ready) begin
                chk("sweep1_pending", 64'(q1.size()), 64'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("sweep1_res", {resp1_ovf, resp1_sum}, e);
                end
                ops++;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc0) begin req0_valid = 1'b0; req0_a = ~req0_a; end
            if (acc1) begin req1_valid = 1'b0; req1_b = ~req1_b; end
            cyc++;
        end
        chk("sweep_ops", 64'(ops), 64'd1000);
        chk("sweep_leftover", 64'(q0.size() + q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
